// File: rtl/down12_pkg.sv
// Shared definitions for the modulo-12 counter family: state encoding,
// default sizing and the load-value clamp.
package down12_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 12;

    // Values outside the count range saturate to the top of the range.
    function automatic int clampLoad(input int value, input int modulus);
        return (value >= modulus) ? (modulus - 1) : value;
    endfunction

endpackage

// File: rtl/down_counter12_if.sv
// Control/status bundle of the loadable down-counter; the master drives the
// enable, load and mode inputs, the slave is the counter itself.
interface down_counter12_if #(
    parameter int WIDTH = down12_pkg::WIDTH
);

    logic             EN;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic             MODE;
    logic [WIDTH-1:0] Q;
    logic             BO;
    logic             DONE;
    logic             BUSY;

    modport master (
        output EN, LD, D, MODE,
        input  Q, BO, DONE, BUSY
    );

    modport slave (
        input  EN, LD, D, MODE,
        output Q, BO, DONE, BUSY
    );

endinterface

// File: rtl/down_counter12.sv
// Loadable modulo-12 down-counter with combinational borrow for cascading,
// one-shot or auto-reload operation and a registered expiry pulse.
import down12_pkg::*;

module down_counter12 #(
    parameter int WIDTH   = down12_pkg::WIDTH,
    parameter int MODULUS = down12_pkg::MODULUS
) (
    input  logic             CLK,
    input  logic             MR,
    down_counter12_if.slave  bus
);

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reloadValue;
    logic [WIDTH-1:0] loadValue;
    logic             donePulse;
    logic             borrow;

    assign loadValue = WIDTH'(clampLoad(int'({1'b0, bus.D}), MODULUS));

    // A load in the same cycle suppresses the borrow so the next stage is not
    // enabled by a count that is about to be overwritten.
    assign borrow = (state == RUN) && bus.EN && (count == '0) && !bus.LD;

    always_ff @(posedge CLK) begin
        if (MR) begin
            state       <= IDLE;
            count       <= '0;
            reloadValue <= '0;
            donePulse   <= 1'b0;
        end else if (bus.LD) begin
            state       <= RUN;
            count       <= loadValue;
            reloadValue <= loadValue;
            donePulse   <= 1'b0;
        end else begin
            donePulse <= 1'b0;
            if (state == RUN && bus.EN) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else begin
                    donePulse <= 1'b1;
                    if (bus.MODE) begin
                        count <= reloadValue;
                    end else begin
                        state <= EXPIRED;
                    end
                end
            end
        end
    end

    assign bus.Q    = count;
    assign bus.BO   = borrow;
    assign bus.DONE = donePulse;
    assign bus.BUSY = (state == RUN);

endmodule

// File: tb/tb_down_counter12.sv
// Self-checking bench for down_counter12: directed scenarios followed by
// randomized traffic, all compared against a behavioural timer model.
module tb_down_counter12;

    localparam int MOD      = 12;
    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_EXPIRED = 2;

    logic clock;
    logic reset;

    down_counter12_if #(.WIDTH(4)) busIf ();

    down_counter12 #(.WIDTH(4), .MODULUS(MOD)) dut (
        .CLK (clock),
        .MR  (reset),
        .bus (busIf.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int assertCount = 0;
    int failCount   = 0;
    int cycleNum    = 0;

    // Behavioural model of the interval timer.
    int mRemaining;
    int mInterval;
    int mPhase;
    bit mDone;
    int mBorrows;

    int boObserved;
    int doneObserved;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d",
                     tag, cycleNum, observed, expected);
        end
    endtask

    task automatic modelReset();
        mRemaining = 0;
        mInterval  = 0;
        mPhase     = PH_IDLE;
        mDone      = 1'b0;
    endtask

    // Advance the model over one clock edge.
    task automatic modelStep(input bit mr, input bit ld, input int d, input bit mode, input bit en);
        if (mr) begin
            modelReset();
        end else if (ld) begin
            mInterval  = (d > MOD - 1) ? MOD - 1 : d;
            mRemaining = mInterval;
            mPhase     = PH_RUN;
            mDone      = 1'b0;
        end else begin
            mDone = 1'b0;
            if (mPhase == PH_RUN && en) begin
                if (mRemaining > 0) begin
                    mRemaining = mRemaining - 1;
                end else begin
                    mDone = 1'b1;
                    mBorrows++;
                    if (mode) mRemaining = mInterval;
                    else      mPhase     = PH_EXPIRED;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then step across the edge.
    task automatic applyStimulus(input bit mr, input bit ld, input int d, input bit mode, input bit en);
        bit expBo;
        reset       = mr;
        busIf.LD    = ld;
        busIf.D     = 4'(d);
        busIf.MODE  = mode;
        busIf.EN    = en;
        #3;
        expBo = (mPhase == PH_RUN) && en && (mRemaining == 0) && !ld;
        checkOutput("Q",    int'(busIf.Q),    mRemaining);
        checkOutput("BUSY", int'(busIf.BUSY), (mPhase == PH_RUN) ? 1 : 0);
        checkOutput("DONE", int'(busIf.DONE), mDone ? 1 : 0);
        checkOutput("BO",   int'(busIf.BO),   expBo ? 1 : 0);
        if (busIf.BO)   boObserved++;
        if (busIf.DONE) doneObserved++;
        @(posedge clock);
        modelStep(mr, ld, d, mode, en);
        cycleNum++;
        #1;
    endtask

    initial begin
        int borrowsBefore;
        bit rMode;

        reset      = 1'b1;
        busIf.LD   = 1'b0;
        busIf.D    = '0;
        busIf.MODE = 1'b0;
        busIf.EN   = 1'b0;
        mBorrows   = 0;
        @(posedge clock);
        #1;
        modelReset();

        // Reset dominates a simultaneous load.
        applyStimulus(1, 1, 5, 0, 1);
        applyStimulus(1, 1, 5, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("reset_Q", int'(busIf.Q), 0);

        // One-shot countdown from 3.
        applyStimulus(0, 1, 3, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("oneshot_busy", int'(busIf.BUSY), 0);

        // Auto-reload from 2 with gated enable.
        applyStimulus(0, 1, 2, 1, 0);
        boObserved    = 0;
        doneObserved  = 0;
        borrowsBefore = mBorrows;
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1, (i % 2) == 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("reload_done_vs_bo", doneObserved, boObserved);
        checkOutput("reload_borrows", boObserved, mBorrows - borrowsBefore);

        // Clamp and zero loads.
        applyStimulus(0, 1, 15, 0, 0);
        checkOutput("clamp_Q", int'(busIf.Q), 11);
        applyStimulus(0, 1, 0, 1, 1);
        boObserved   = 0;
        doneObserved = 0;
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("zero_bo_count", boObserved, 6);
        checkOutput("zero_done_count", doneObserved, 5);

        // Load colliding with a borrow.
        applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 7, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("collide_Q", int'(busIf.Q), 7);

        // Reset mid-count, then enable is ignored.
        applyStimulus(0, 1, 6, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("mr_idle_Q", int'(busIf.Q), 0);

        // Randomized traffic.
        rMode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) rMode = ~rMode;
            applyStimulus($urandom_range(39) == 0,
                          $urandom_range(7) == 0,
                          int'($urandom_range(15)),
                          rMode,
                          $urandom_range(9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
